// File: rtl/tmr_vote_monitor.sv
// Bitwise majority voter for three lock-stepped cores, with per-core disagreement
// tracking and a registered active-low resync request back into the sync controller.
module tmr_vote_monitor #(
   parameter int DATA_W         = 32,
   parameter int MISMATCH_LIMIT = 4,
   parameter int SKEW_LIMIT     = 4,
   parameter int RESYNC_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync_active,
   input  logic [DATA_W-1:0] core_a_data,
   input  logic [DATA_W-1:0] core_b_data,
   input  logic [DATA_W-1:0] core_c_data,
   input  logic              core_a_valid,
   input  logic              core_b_valid,
   input  logic              core_c_valid,
   output logic [DATA_W-1:0] voted_data,
   output logic              voted_valid,
   output logic              fault_a,
   output logic              fault_b,
   output logic              fault_c,
   output logic              resync_req_n,
   output logic [1:0]        mon_state,
   output logic [7:0]        resync_count
);

   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_MONITOR   = 2'b01;
   localparam logic [1:0] ST_RESYNC    = 2'b10;
   localparam logic [1:0] ST_WAIT_SYNC = 2'b11;

   localparam int            PW         = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(RESYNC_CYCLES - 1);
   localparam logic [7:0]    MM_LIMIT   = 8'(MISMATCH_LIMIT);
   localparam logic [7:0]    SK_LIMIT   = 8'(SKEW_LIMIT);

   function automatic logic [DATA_W-1:0] f_majority(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [1:0]        r_state,    w_state_nxt;
   logic [7:0]        r_mm_a,     w_mm_a_nxt;
   logic [7:0]        r_mm_b,     w_mm_b_nxt;
   logic [7:0]        r_mm_c,     w_mm_c_nxt;
   logic [7:0]        r_skew,     w_skew_nxt;
   logic [PW-1:0]     r_pulse,    w_pulse_nxt;
   logic              r_seen_low, w_seen_low_nxt;
   logic [DATA_W-1:0] r_vdata,    w_vdata_nxt;
   logic              r_vvalid,   w_vvalid_nxt;
   logic [2:0]        r_fault,    w_fault_nxt;
   logic              r_resync_n, w_resync_n_nxt;
   logic [7:0]        r_count,    w_count_nxt;

   logic              w_sample;
   logic              w_skewed;
   logic              w_triple;
   logic              w_trig;
   logic [DATA_W-1:0] w_maj;
   logic [2:0]        w_dis;
   logic [7:0]        w_mm_a_upd;
   logic [7:0]        w_mm_b_upd;
   logic [7:0]        w_mm_c_upd;
   logic [7:0]        w_skew_upd;

   assign w_sample = core_a_valid & core_b_valid & core_c_valid;
   assign w_skewed = (core_a_valid ^ core_b_valid) | (core_b_valid ^ core_c_valid);
   assign w_maj    = f_majority(core_a_data, core_b_data, core_c_data);
   assign w_dis    = {core_c_data != w_maj, core_b_data != w_maj, core_a_data != w_maj};
   assign w_triple = (core_a_data != core_b_data) & (core_a_data != core_c_data) &
                     (core_b_data != core_c_data);

   // Counters hold between sample events; the limit check sees the post-update value.
   assign w_mm_a_upd = !w_sample ? r_mm_a : (w_dis[0] ? r_mm_a + 8'd1 : 8'd0);
   assign w_mm_b_upd = !w_sample ? r_mm_b : (w_dis[1] ? r_mm_b + 8'd1 : 8'd0);
   assign w_mm_c_upd = !w_sample ? r_mm_c : (w_dis[2] ? r_mm_c + 8'd1 : 8'd0);
   assign w_skew_upd = w_skewed ? r_skew + 8'd1 : 8'd0;
   assign w_trig     = (w_mm_a_upd == MM_LIMIT) | (w_mm_b_upd == MM_LIMIT) |
                       (w_mm_c_upd == MM_LIMIT) | (w_skew_upd == SK_LIMIT) |
                       (w_sample & w_triple);

   // Next-state and output computation for the monitor FSM.
   always_comb begin
      w_state_nxt    = r_state;
      w_mm_a_nxt     = r_mm_a;
      w_mm_b_nxt     = r_mm_b;
      w_mm_c_nxt     = r_mm_c;
      w_skew_nxt     = r_skew;
      w_pulse_nxt    = r_pulse;
      w_seen_low_nxt = r_seen_low;
      w_vdata_nxt    = r_vdata;
      w_vvalid_nxt   = 1'b0;
      w_fault_nxt    = r_fault;
      w_resync_n_nxt = r_resync_n;
      w_count_nxt    = r_count;
      case (r_state)
         ST_IDLE: begin
            if (sync_active) begin
               w_state_nxt = ST_MONITOR;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MONITOR: begin
            if (!sync_active) begin
               w_state_nxt = ST_IDLE;
               w_mm_a_nxt  = 8'd0;
               w_mm_b_nxt  = 8'd0;
               w_mm_c_nxt  = 8'd0;
               w_skew_nxt  = 8'd0;
            end else begin
               w_fault_nxt = r_fault | ({3{w_sample}} & w_dis);
               if (w_trig) begin
                  w_state_nxt    = ST_RESYNC;
                  w_mm_a_nxt     = 8'd0;
                  w_mm_b_nxt     = 8'd0;
                  w_mm_c_nxt     = 8'd0;
                  w_skew_nxt     = 8'd0;
                  w_pulse_nxt    = '0;
                  w_seen_low_nxt = 1'b0;
                  w_resync_n_nxt = 1'b0;
                  w_count_nxt    = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
               end else begin
                  w_mm_a_nxt   = w_mm_a_upd;
                  w_mm_b_nxt   = w_mm_b_upd;
                  w_mm_c_nxt   = w_mm_c_upd;
                  w_skew_nxt   = w_skew_upd;
                  w_vvalid_nxt = w_sample;
                  w_vdata_nxt  = w_sample ? w_maj : r_vdata;
               end
            end
         end
         ST_RESYNC: begin
            w_seen_low_nxt = r_seen_low | ~sync_active;
            if (r_pulse == PULSE_LAST) begin
               w_state_nxt    = ST_WAIT_SYNC;
               w_resync_n_nxt = 1'b1;
            end else begin
               w_pulse_nxt = r_pulse + PW'(1);
            end
         end
         ST_WAIT_SYNC: begin
            // A level left over from before the pulse must not re-arm monitoring.
            if (sync_active && r_seen_low) begin
               w_state_nxt = ST_MONITOR;
            end else begin
               w_seen_low_nxt = r_seen_low | ~sync_active;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_resync_n_nxt = 1'b1;
         end
      endcase
   end

   // State and output registers; resync_req_n releases asynchronously on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_mm_a     <= 8'd0;
         r_mm_b     <= 8'd0;
         r_mm_c     <= 8'd0;
         r_skew     <= 8'd0;
         r_pulse    <= '0;
         r_seen_low <= 1'b0;
         r_vdata    <= '0;
         r_vvalid   <= 1'b0;
         r_fault    <= 3'b000;
         r_resync_n <= 1'b1;
         r_count    <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_mm_a     <= w_mm_a_nxt;
         r_mm_b     <= w_mm_b_nxt;
         r_mm_c     <= w_mm_c_nxt;
         r_skew     <= w_skew_nxt;
         r_pulse    <= w_pulse_nxt;
         r_seen_low <= w_seen_low_nxt;
         r_vdata    <= w_vdata_nxt;
         r_vvalid   <= w_vvalid_nxt;
         r_fault    <= w_fault_nxt;
         r_resync_n <= w_resync_n_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign voted_data   = r_vdata;
   assign voted_valid  = r_vvalid;
   assign fault_a      = r_fault[0];
   assign fault_b      = r_fault[1];
   assign fault_c      = r_fault[2];
   assign resync_req_n = r_resync_n;
   assign mon_state    = r_state;
   assign resync_count = r_count;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: behavioural model compared every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
`timescale 1ns/1ps
module tb_tmr_vote_monitor;
   localparam int DW = 32;
   localparam int MM = 4;
   localparam int SK = 4;
   localparam int RC = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sync_active = 1'b0;
   logic [DW-1:0] a_d = '0, b_d = '0, c_d = '0;
   logic          a_v = 1'b0, b_v = 1'b0, c_v = 1'b0;
   logic [DW-1:0] voted_data;
   logic          voted_valid, fault_a, fault_b, fault_c, resync_req_n;
   logic [1:0]    mon_state;
   logic [7:0]    resync_count;

   always #5 clk = ~clk;

   tmr_vote_monitor #(.DATA_W(DW), .MISMATCH_LIMIT(MM), .SKEW_LIMIT(SK), .RESYNC_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .sync_active(sync_active),
      .core_a_data(a_d), .core_b_data(b_d), .core_c_data(c_d),
      .core_a_valid(a_v), .core_b_valid(b_v), .core_c_valid(c_v),
      .voted_data(voted_data), .voted_valid(voted_valid),
      .fault_a(fault_a), .fault_b(fault_b), .fault_c(fault_c),
      .resync_req_n(resync_req_n), .mon_state(mon_state), .resync_count(resync_count));

   int n_vec = 0;
   int n_err = 0;

   // model of the observable behaviour (mode uses the mon_state encoding)
   int            m_mode;
   int            m_cnt[3];
   int            m_skew;
   int            m_left;
   bit            m_seen_low;
   logic [DW-1:0] m_vdata;
   bit            m_vvalid;
   bit            m_fault[3];
   bit            m_rn;
   int            m_count;

   task automatic model_reset();
      m_mode = 0; m_cnt = '{0, 0, 0}; m_skew = 0; m_left = 0; m_seen_low = 0;
      m_vdata = '0; m_vvalid = 0; m_fault = '{0, 0, 0}; m_rn = 1; m_count = 0;
   endtask

   task automatic model_step();
      logic [DW-1:0] d[3];
      logic [DW-1:0] maj;
      bit            v[3];
      bit            trig;
      int            ones;
      d[0] = a_d; d[1] = b_d; d[2] = c_d;
      v[0] = a_v; v[1] = b_v; v[2] = c_v;
      m_vvalid = 0;
      case (m_mode)
         0: if (sync_active) m_mode = 1;
         1: begin
            if (!sync_active) begin
               m_mode = 0; m_cnt = '{0, 0, 0}; m_skew = 0;
            end else begin
               trig = 0;
               if (v[0] == v[1] && v[1] == v[2]) m_skew = 0;
               else m_skew++;
               if (m_skew == SK) trig = 1;
               if (v[0] && v[1] && v[2]) begin
                  for (int i = 0; i < DW; i++) begin
                     ones = int'(d[0][i]) + int'(d[1][i]) + int'(d[2][i]);
                     maj[i] = (ones >= 2);
                  end
                  for (int k = 0; k < 3; k++) begin
                     if (d[k] != maj) begin
                        m_fault[k] = 1; m_cnt[k]++;
                        if (m_cnt[k] == MM) trig = 1;
                     end else begin
                        m_cnt[k] = 0;
                     end
                  end
                  if (d[0] != d[1] && d[0] != d[2] && d[1] != d[2]) trig = 1;
                  if (!trig) begin m_vvalid = 1; m_vdata = maj; end
               end
               if (trig) begin
                  m_mode = 2; m_cnt = '{0, 0, 0}; m_skew = 0; m_left = RC;
                  m_seen_low = 0; m_rn = 0;
                  if (m_count < 255) m_count++;
               end
            end
         end
         2: begin
            if (!sync_active) m_seen_low = 1;
            m_left--;
            if (m_left == 0) begin m_mode = 3; m_rn = 1; end
         end
         3: begin
            if (sync_active && m_seen_low) m_mode = 1;
            else if (!sync_active) m_seen_low = 1;
         end
         default: ;
      endcase
   endtask

   task automatic check();
      n_vec++;
      if (voted_data !== m_vdata) begin n_err++; $display("FAIL voted_data t=%0t got %h want %h", $time, voted_data, m_vdata); end
      if (voted_valid !== m_vvalid) begin n_err++; $display("FAIL voted_valid t=%0t got %b want %b", $time, voted_valid, m_vvalid); end
      if ({fault_c, fault_b, fault_a} !== {m_fault[2], m_fault[1], m_fault[0]}) begin
         n_err++; $display("FAIL faults t=%0t got %b%b%b want %b%b%b", $time, fault_c, fault_b, fault_a, m_fault[2], m_fault[1], m_fault[0]);
      end
      if (resync_req_n !== m_rn) begin n_err++; $display("FAIL resync_req_n t=%0t got %b want %b", $time, resync_req_n, m_rn); end
      if (mon_state !== 2'(m_mode)) begin n_err++; $display("FAIL mon_state t=%0t got %0d want %0d", $time, mon_state, m_mode); end
      if (resync_count !== 8'(m_count)) begin n_err++; $display("FAIL resync_count t=%0t got %0d want %0d", $time, resync_count, m_count); end
   endtask

   task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check();
   endtask

   task automatic drive(input logic av, input logic bv, input logic cv,
                        input logic [DW-1:0] ad, input logic [DW-1:0] bd, input logic [DW-1:0] cd);
      a_v = av; b_v = bv; c_v = cv; a_d = ad; b_d = bd; c_d = cd;
   endtask

   task automatic recover();
      int guard;
      guard = 0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      sync_active = 1'b0;
      while (m_mode != 3 && guard < 64) begin cycle(); guard++; end
      if (m_mode != 3) begin n_err++; $display("FAIL recover_timeout t=%0t", $time); end
      sync_active = 1'b1;
      cycle();
      lit("recover_state", 64'(mon_state), 64'd1);
   endtask

   initial begin
      int low;
      int guard;
      model_reset();
      @(posedge clk); #1;
      check();
      lit("reset_rn", 64'(resync_req_n), 64'd1);
      rst = 1'b0;
      sync_active = 1'b1;
      cycle();
      lit("idle_to_monitor", 64'(mon_state), 64'd1);

      // clean vote
      drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      cycle();
      lit("clean_data", 64'(voted_data), 64'hDEADBEEF);
      lit("clean_valid", 64'(voted_valid), 64'd1);
      lit("clean_faults", 64'({fault_a, fault_b, fault_c}), 64'd0);

      // single upset on b, then clean samples clear its counter
      drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h1, 32'h0);
      cycle();
      lit("upset_data", 64'(voted_data), 64'h0);
      lit("upset_fault_b", 64'(fault_b), 64'd1);
      drive(1'b1, 1'b1, 1'b1, 32'h55, 32'h55, 32'h55);
      for (int i = 0; i < 3; i++) cycle();
      drive(1'b1, 1'b1, 1'b1, 32'h7, 32'h3, 32'h7);
      for (int i = 0; i < 3; i++) cycle();
      lit("b_counter_cleared", 64'(mon_state), 64'd1);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      cycle();
      lit("idle_cycle_no_valid", 64'(voted_valid), 64'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h9, 32'h9, 32'h9);
      cycle();

      // persistent fault on c
      drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h10, 32'h11);
      for (int i = 0; i < 3; i++) cycle();
      lit("c_before_limit", 64'(mon_state), 64'd1);
      cycle();
      lit("c_trigger_state", 64'(mon_state), 64'd2);
      lit("c_trigger_count", 64'(resync_count), 64'd1);
      lit("c_trigger_valid", 64'(voted_valid), 64'd0);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      low = 0; guard = 0;
      while (resync_req_n == 1'b0 && guard < 40) begin
         low++; guard++;
         if (guard == 3) sync_active = 1'b0;
         cycle();
      end
      lit("pulse_length", 64'(low), 64'd16);
      lit("after_pulse_state", 64'(mon_state), 64'd3);
      sync_active = 1'b1;
      cycle();
      lit("resynced_state", 64'(mon_state), 64'd1);

      // triple disagreement
      drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h4);
      cycle();
      lit("triple_state", 64'(mon_state), 64'd2);
      lit("triple_valid", 64'(voted_valid), 64'd0);
      lit("triple_fault_a", 64'(fault_a), 64'd1);
      recover();

      // valid skew
      drive(1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 32'h1);
      for (int i = 0; i < 3; i++) cycle();
      lit("skew_before_limit", 64'(mon_state), 64'd1);
      cycle();
      lit("skew_trigger_state", 64'(mon_state), 64'd2);
      recover();

      // stale sync_active held high through the pulse
      drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h4);
      cycle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < RC + 6; i++) cycle();
      lit("stale_wait", 64'(mon_state), 64'd3);
      sync_active = 1'b0;
      cycle();
      lit("stale_low_seen", 64'(mon_state), 64'd3);
      sync_active = 1'b1;
      cycle();
      lit("stale_released", 64'(mon_state), 64'd1);

      // asynchronous reset in pulse cycle 5
      drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h4);
      cycle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) cycle();
      lit("mid_pulse_low", 64'(resync_req_n), 64'd0);
      rst = 1'b1;
      #2;
      model_reset();
      check();
      lit("async_rn", 64'(resync_req_n), 64'd1);
      lit("async_state", 64'(mon_state), 64'd0);
      lit("async_count", 64'(resync_count), 64'd0);
      @(posedge clk); #1;
      check();
      rst = 1'b0;
      cycle();

      // saturation of resync_count
      for (int n = 0; n < 257; n++) begin
         sync_active = 1'b1;
         drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h4);
         cycle();
         recover();
      end
      lit("count_saturated", 64'(resync_count), 64'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
